muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL provide parameters: OP_MULT default 2'b00, signed multiply; OP_MULTU default 2'b01, unsigned multiply; OP_DIV default 2'b10, signed divide; OP_DIVU default 2'b11, unsigned divide.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: `clk  in  1  rising-edge clock`.
REQ-003 `rst_n  in  1  asynchronous active-low reset`.
REQ-004 `start  in  1  EX-stage request to begin op`.
REQ-005 `op  in  2  operation select (REQ-001 encodings)`.
REQ-006 `src_a  in  32  rs value (multiplicand/dividend)`.
REQ-007 `src_b  in  32  rt value (multiplier/divisor)`.
REQ-008 `flush  in  1  abort in-flight op (branch/exception)`.
REQ-009 `mthi_we, mtlo_we  in  1 each  MTHI/MTLO write strobes`.
REQ-010 `mt_data  in  32  MTHI/MTLO write data`.
REQ-011 `mf_req  in  1  MFHI/MFLO in decode/EX needs HI/LO`.
REQ-012 `busy  out  1  op in flight (registered)`.
REQ-013 `stall  out  1  freeze pipeline front end (combinational)`.
REQ-014 `done  out  1  one-cycle registered completion pulse`.
REQ-015 `hi, lo  out  32 each  architectural HI/LO registers`.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FIX; only IDLE accepts start.
REQ-017 IDLE + start (flush=0) SHALL latch op and operands, load iteration counter = 0, and go to RUN.
REQ-018 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide, on 32-bit magnitudes; after counter reaches 31, go to FIX.
REQ-019 Signed ops SHALL convert operands to magnitudes on accept; FIX SHALL negate the product if the signs differ, negate the quotient if the signs differ, and give the remainder the sign of the dividend.
REQ-020 FIX SHALL write HI=product[63:32]/remainder and LO=product[31:0]/quotient, then go to IDLE; done SHALL be high the following cycle, coincident with new hi/lo.
REQ-021 Latency: start sampled at edge E0; hi/lo valid and done high after edge E34.
REQ-022 Divide by zero SHALL complete with normal latency and give HI=dividend (original src_a) and LO=32'hFFFFFFFF.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (wraps, no trap).
REQ-024 busy SHALL be high in RUN and FIX.
REQ-025 stall = busy & (start | mf_req | mthi_we | mtlo_we); a start while busy is ignored.
REQ-026 In IDLE, mthi_we/mtlo_we SHALL update hi/lo at the next edge; if start is accepted in the same cycle, the write still lands, and the op result later overwrites it.
REQ-027 flush SHALL, in any state, force IDLE at the next edge with no done and no hi/lo change; flush with start in IDLE SHALL reject start.
REQ-028 flush and a FIX-state write in the same cycle: flush wins, hi/lo unchanged.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and operand latches=0; stall follows as 0.
REQ-030 Reset mid-RUN SHALL discard the op; after release, the next start behaves as from power-up.

Configuration
REQ-031 With macro MULDIV_FAST_MUL_EN defined, MULT/MULTU SHALL go IDLE->FIX directly using a single-cycle 64-bit product; hi/lo valid and done after edge E2; divides remain at 34.
REQ-032 Without MULDIV_FAST_MUL_EN, all ops SHALL use the 32-step iterative path (REQ-021).

Verification
REQ-033 MULTU src_a=0xFFFFFFFF, src_b=2 -> HI=0x00000001, LO=0xFFFFFFFE, done after E34 (E2 with macro).
REQ-034 MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-035 DIV -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 10/0 -> HI=0x0000000A, LO=0xFFFFFFFF.
REQ-036 Start DIVU, assert mf_req each cycle -> stall=1 from E1 through E33, stall=0 when done=1.
REQ-037 Preload hi=0x11, lo=0x22 via mt writes; start MULT; flush at E10 -> busy=0 after E11, no done, hi/lo stay 0x11/0x22.
REQ-038 rst_n low at E15 of a DIV -> busy, done, hi, lo = 0 immediately; fresh DIVU 9/4 -> LO=2, HI=1.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multicycle radix-2 multiply/divide sequencer that owns the architectural HI/LO registers.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle MULT/MULTU product, divides stay iterative).
module muldiv_sequencer #(
    parameter logic [1:0] OP_MULT  = 2'b00,
    parameter logic [1:0] OP_MULTU = 2'b01,
    parameter logic [1:0] OP_DIV   = 2'b10,
    parameter logic [1:0] OP_DIVU  = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    input  logic        mf_req,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] accHi_q, accHi_d;
    logic [31:0] accLo_q, accLo_d;
    logic [31:0] bMag_q, bMag_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  count_q, count_d;
    logic        negRes_q, negRes_d;
    logic        negRem_q, negRem_d;
    logic        divZero_q, divZero_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        opSigned;
    logic        isMulQ;
    logic        isDivQ;
    logic [31:0] aMag;
    logic [31:0] bMagIn;
    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic [32:0] divDiff;
    logic [63:0] prodMag;
    logic [63:0] prodFix;
    logic [31:0] quoFix;
    logic [31:0] remFix;

    assign opSigned = (op == OP_MULT) || (op == OP_DIV);
    assign aMag     = (opSigned && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign bMagIn   = (opSigned && src_b[31]) ? (32'd0 - src_b) : src_b;
    assign isMulQ   = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign isDivQ   = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Multiply keeps {partial product, multiplier} in accHi/accLo and shifts right;
    // divide keeps {remainder, dividend->quotient} and shifts left.
    assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, bMag_q} : 33'd0);
    assign divShift = {accHi_q, accLo_q[31]};
    assign divDiff  = divShift - {1'b0, bMag_q};

`ifdef MULDIV_FAST_MUL_EN
    assign prodMag = {32'd0, accLo_q} * {32'd0, bMag_q};
`else
    assign prodMag = {accHi_q, accLo_q};
`endif
    assign prodFix = negRes_q ? (64'd0 - prodMag) : prodMag;
    assign quoFix  = negRes_q ? (32'd0 - accLo_q) : accLo_q;
    assign remFix  = negRem_q ? (32'd0 - accHi_q) : accHi_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        accHi_d    = accHi_q;
        accLo_d    = accLo_q;
        bMag_d     = bMag_q;
        dividend_d = dividend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        count_d    = count_q;
        negRes_d   = negRes_q;
        negRem_d   = negRem_q;
        divZero_d  = divZero_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mthi_we) hi_d = mt_data;
                if (mtlo_we) lo_d = mt_data;
                if (start && !flush) begin
                    op_d       = op;
                    accHi_d    = 32'd0;
                    accLo_d    = aMag;
                    bMag_d     = bMagIn;
                    dividend_d = src_a;
                    count_d    = 5'd0;
                    negRes_d   = opSigned && (src_a[31] ^ src_b[31]);
                    negRem_d   = opSigned && src_a[31];
                    divZero_d  = (src_b == 32'd0);
`ifdef MULDIV_FAST_MUL_EN
                    state_d    = ((op == OP_MULT) || (op == OP_MULTU)) ? FIX : RUN;
`else
                    state_d    = RUN;
`endif
                end
            end
            RUN: begin
                if (isDivQ) begin
                    if (!divDiff[32]) begin
                        accHi_d = divDiff[31:0];
                        accLo_d = {accLo_q[30:0], 1'b1};
                    end else begin
                        accHi_d = divShift[31:0];
                        accLo_d = {accLo_q[30:0], 1'b0};
                    end
                end else begin
                    accHi_d = mulSum[32:1];
                    accLo_d = {mulSum[0], accLo_q[31:1]};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                if (isMulQ) begin
                    hi_d = prodFix[63:32];
                    lo_d = prodFix[31:0];
                end else if (divZero_q) begin
                    hi_d = dividend_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = remFix;
                    lo_d = quoFix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // An abort wins over everything, including a result write in FIX.
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            accHi_q    <= 32'd0;
            accLo_q    <= 32'd0;
            bMag_q     <= 32'd0;
            dividend_q <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            count_q    <= 5'd0;
            negRes_q   <= 1'b0;
            negRem_q   <= 1'b0;
            divZero_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            accHi_q    <= accHi_d;
            accLo_q    <= accLo_d;
            bMag_q     <= bMag_d;
            dividend_q <= dividend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            count_q    <= count_d;
            negRes_q   <= negRes_d;
            negRem_q   <= negRem_d;
            divZero_q  <= divZero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q & (start | mf_req | mthi_we | mtlo_we);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, directed pipeline-interaction sequences,
// and randomized operations compared against a plain-arithmetic HI/LO model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] mt_data = 32'd0;
    logic        mf_req = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[9];

    muldiv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data), .mf_req(mf_req),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference result {HI, LO} straight from integer arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (o == OP_MULT) begin
            res = 64'(sa * sb);
        end else if (o == OP_MULTU) begin
            res = ua * ub;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else begin
            if (o == OP_DIV) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
            end
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    function automatic int expLatency(input logic [1:0] o);
        int lat;
        lat = 34;
`ifdef MULDIV_FAST_MUL_EN
        if (o == OP_MULT || o == OP_MULTU) lat = 2;
`endif
        return lat;
    endfunction

    // Called at the negedge just before edge firstEdge; returns the edge index whose
    // sampling window first shows done high (bounded).
    task automatic waitDone(input int firstEdge, output int doneEdge);
        doneEdge = firstEdge;
        while (!done && doneEdge < 80) begin
            @(posedge clk);
            @(negedge clk);
            doneEdge++;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] gotHi, output logic [31:0] gotLo, output int doneEdge);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitDone(1, doneEdge);
        gotHi = hi;
        gotLo = lo;
    endtask

    task automatic runAndCheck(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        logic [31:0] gHi, gLo;
        int          e;
        applyStimulus(o, a, b, gHi, gLo, e);
        checkOutput({name, " hi"}, gHi, expHi);
        checkOutput({name, " lo"}, gLo, expLo);
        checkOutput({name, " done edge"}, 32'(e), 32'(expLatency(o)));
    endtask

    initial begin
        logic [31:0] gHi, gLo;
        logic [63:0] exp;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [1:0]  flushOp;
        int          e, k;
        bit          sawDone;

        vecs[0] = '{"MULTU max*2",      OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
        vecs[1] = '{"MULT min*min",     OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{"DIV -7/2",         OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"DIVU 10/0",        OP_DIVU,  32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF};
        vecs[4] = '{"DIV min/-1",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{"DIVU 9/4",         OP_DIVU,  32'd9,         32'd4,         32'h0000_0001, 32'h0000_0002};
        vecs[6] = '{"MULT -1*3",        OP_MULT,  32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7] = '{"DIV 7/-2",         OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{"DIV -8/0",         OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};

        // Power-up state while held in reset.
        mf_req = 1'b1;
        #12;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mf_req = 1'b0;

        for (int i = 0; i < 9; i++) begin
            runAndCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo);
            @(negedge clk);
            checkOutput({vecs[i].name, " done pulse width"}, 32'(done), 32'd0);
        end

        // Stall while busy with a pending MFHI/MFLO; a start during the op is ignored.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        mf_req = 1'b1;
        for (int s = 1; s <= 34; s++) begin
            if (s == 5) begin
                start = 1'b1; op = OP_MULTU; src_a = 32'hFFFF; src_b = 32'hFFFF;
            end
            if (s == 6) start = 1'b0;
            #1;
            checkOutput($sformatf("stall at E%0d", s), 32'(stall), (s <= 33) ? 32'd1 : 32'd0);
            if (s < 34) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        checkOutput("stall test done", 32'(done), 32'd1);
        checkOutput("stall test hi", hi, 32'd6);
        checkOutput("stall test lo", lo, 32'd142);
        mf_req = 1'b0;

        // MT write in the accept cycle lands, then the result overwrites it.
        @(negedge clk);
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'h55;
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0; start = 1'b0;
        checkOutput("mt+start hi", hi, 32'h55);
        checkOutput("mt+start lo", lo, 32'h55);
        checkOutput("mt+start busy", 32'(busy), 32'd1);
        waitDone(1, e);
        checkOutput("mt+start done edge", 32'(e), 32'd34);
        checkOutput("mt+start result hi", hi, 32'd2);
        checkOutput("mt+start result lo", lo, 32'd14);

        // Preload HI/LO, start an iterative op, flush it at E10.
        @(negedge clk);
        mthi_we = 1'b1; mt_data = 32'h11;
        @(posedge clk);
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b1; mt_data = 32'h22;
        @(posedge clk);
        @(negedge clk);
        mtlo_we = 1'b0;
        checkOutput("preload hi", hi, 32'h11);
        checkOutput("preload lo", lo, 32'h22);
`ifdef MULDIV_FAST_MUL_EN
        flushOp = OP_DIV;
`else
        flushOp = OP_MULT;
`endif
        start = 1'b1; op = flushOp; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 10) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush busy after E11", 32'(busy), 32'd0);
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("flush no done", 32'(sawDone), 32'd0);
        checkOutput("flush hi kept", hi, 32'h11);
        checkOutput("flush lo kept", lo, 32'h22);

        // Flush together with start in IDLE rejects the start.
        start = 1'b1; flush = 1'b1; op = OP_MULTU; src_a = 32'd6; src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("flush+start busy", 32'(busy), 32'd0);
        sawDone = 1'b0;
        repeat (36) begin
            @(posedge clk);
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("flush+start no done", 32'(sawDone), 32'd0);
        checkOutput("flush+start lo kept", lo, 32'h22);

        // Asynchronous reset in the middle of a divide.
        start = 1'b1; op = OP_DIV; src_a = 32'hFFFF_FF9C; src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 15) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        mf_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        checkOutput("midrun reset busy", 32'(busy), 32'd0);
        checkOutput("midrun reset done", 32'(done), 32'd0);
        checkOutput("midrun reset hi", hi, 32'd0);
        checkOutput("midrun reset lo", lo, 32'd0);
        checkOutput("midrun reset stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mf_req = 1'b0;
        runAndCheck("post-reset DIVU 9/4", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

        // Randomized operations against the arithmetic model.
        for (int r = 0; r < 24; r++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'd0 - $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 255);
            exp = refModel(ro, ra, rb);
            applyStimulus(ro, ra, rb, gHi, gLo, e);
            checkOutput($sformatf("rand%0d op%0d a=%08h b=%08h hi", r, ro, ra, rb), gHi, exp[63:32]);
            checkOutput($sformatf("rand%0d op%0d a=%08h b=%08h lo", r, ro, ra, rb), gLo, exp[31:0]);
            checkOutput($sformatf("rand%0d done edge", r), 32'(e), 32'(expLatency(ro)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
